multicycle_control_fsm: RTL

Control sequencer for the multi-cycle RISC-V core. Replaces the single-cycle combinational control path and steps one shared datapath through fetch, decode, execute, memory and writeback: register file, ALU, a single unified memory port, and the PC, IR, ALUOut and MDR registers. Supports R-type ALU, I-type ALU, LW, SW, BEQ and BNE. Any other encoding traps.

---
 rtl/multicycle_control_fsm_if.sv | 34 +++
 rtl/multicycle_control_fsm.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multi-cycle sequencer and the shared datapath.
// master = sequencer side, slave = datapath/memory side.
interface multicycle_control_fsm_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic [1:0] result_src;
  logic [3:0] alu_control;
  logic       retire;
  logic       trap;

  modport master (
    input  opcode, funct3, funct7, zero, mem_ready,
    output mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, imm_src, result_src, alu_control, retire, trap
  );

  modport slave (
    output opcode, funct3, funct7, zero, mem_ready,
    input  mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, imm_src, result_src, alu_control, retire, trap
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer (R/I ALU, LW, SW, BEQ, BNE; others trap).
// Latency: 3 (branch) / 4 (ALU, SW) / 5 (LW) cycles plus one per mem_ready=0 cycle.
// Backpressure: mem_req and its address/write select hold until mem_ready.
module multicycle_control_fsm (
  input  logic                    clk,
  input  logic                    rst,
  multicycle_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEMADR,
    S_MEMREAD, S_MEMWB, S_MEMWRITE, S_BRANCH, S_TRAP
  } state_t;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] alu_base;
  logic [3:0] alu_r;
  logic [3:0] alu_i;
  logic       f7_zero;
  logic       f7_alt;
  logic       r_legal;
  logic       i_legal;
  logic       br_legal;
  logic       is_store;

  assign f7_zero  = (bus.funct7 == 7'b0000000);
  assign f7_alt   = (bus.funct7 == 7'b0100000);
  assign r_legal  = f7_zero | (f7_alt & ((bus.funct3 == 3'b000) | (bus.funct3 == 3'b101)));
  assign br_legal = (bus.funct3 == 3'b000) | (bus.funct3 == 3'b001);
  assign is_store = (bus.opcode == OP_S);

  always_comb begin
    case (bus.funct3)
      3'b000:  alu_base = ALU_ADD;
      3'b001:  alu_base = ALU_SLL;
      3'b010:  alu_base = ALU_SLT;
      3'b011:  alu_base = ALU_SLTU;
      3'b100:  alu_base = ALU_XOR;
      3'b101:  alu_base = ALU_SRL;
      3'b110:  alu_base = ALU_OR;
      default: alu_base = ALU_AND;
    endcase
    alu_r = alu_base;
    alu_i = alu_base;
    if (f7_alt && bus.funct3 == 3'b000) alu_r = ALU_SUB;
    if (f7_alt && bus.funct3 == 3'b101) begin
      alu_r = ALU_SRA;
      alu_i = ALU_SRA;
    end
    // funct7 of an I-type is immediate bits, so it only matters for shifts
    case (bus.funct3)
      3'b001:  i_legal = f7_zero;
      3'b101:  i_legal = f7_zero | f7_alt;
      default: i_legal = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:    if (bus.mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_R:       state_nxt = S_EXEC_R;
          OP_I:       state_nxt = S_EXEC_I;
          OP_L, OP_S: state_nxt = S_MEMADR;
          OP_B:       state_nxt = S_BRANCH;
          default:    state_nxt = S_TRAP;
        endcase
      end
      S_EXEC_R:   state_nxt = r_legal ? S_ALU_WB : S_TRAP;
      S_EXEC_I:   state_nxt = i_legal ? S_ALU_WB : S_TRAP;
      S_ALU_WB:   state_nxt = S_FETCH;
      S_MEMADR: begin
        if (bus.funct3 != 3'b010) state_nxt = S_TRAP;
        else                      state_nxt = is_store ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD:  if (bus.mem_ready) state_nxt = S_MEMWB;
      S_MEMWB:    state_nxt = S_FETCH;
      S_MEMWRITE: if (bus.mem_ready) state_nxt = S_FETCH;
      S_BRANCH:   state_nxt = br_legal ? S_FETCH : S_TRAP;
      S_TRAP:     state_nxt = S_TRAP;
      default:    state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  // Outputs decode straight from state so strobes drop in the same cycle rst rises.
  always_comb begin
    bus.mem_req     = 1'b0;
    bus.mem_we      = 1'b0;
    bus.adr_src     = 1'b0;
    bus.ir_write    = 1'b0;
    bus.pc_write    = 1'b0;
    bus.reg_write   = 1'b0;
    bus.alu_src_a   = 2'b00;
    bus.alu_src_b   = 2'b00;
    bus.imm_src     = 2'b00;
    bus.result_src  = 2'b00;
    bus.alu_control = ALU_ADD;
    bus.retire      = 1'b0;
    bus.trap        = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          bus.mem_req    = 1'b1;
          bus.alu_src_b  = 2'b10;
          bus.result_src = 2'b10;
          bus.ir_write   = bus.mem_ready;
          bus.pc_write   = bus.mem_ready;
        end
        S_DECODE: begin
          bus.alu_src_a = 2'b01;
          bus.alu_src_b = 2'b01;
          bus.imm_src   = 2'b10;
        end
        S_EXEC_R: begin
          bus.alu_src_a   = 2'b10;
          bus.alu_control = alu_r;
        end
        S_EXEC_I: begin
          bus.alu_src_a   = 2'b10;
          bus.alu_src_b   = 2'b01;
          bus.alu_control = alu_i;
        end
        S_ALU_WB: begin
          bus.reg_write = 1'b1;
          bus.retire    = 1'b1;
        end
        S_MEMADR: begin
          bus.alu_src_a = 2'b10;
          bus.alu_src_b = 2'b01;
          bus.imm_src   = is_store ? 2'b01 : 2'b00;
        end
        S_MEMREAD: begin
          bus.mem_req = 1'b1;
          bus.adr_src = 1'b1;
        end
        S_MEMWB: begin
          bus.reg_write  = 1'b1;
          bus.result_src = 2'b01;
          bus.retire     = 1'b1;
        end
        S_MEMWRITE: begin
          bus.mem_req = 1'b1;
          bus.mem_we  = 1'b1;
          bus.adr_src = 1'b1;
          bus.retire  = bus.mem_ready;
        end
        S_BRANCH: begin
          bus.alu_src_a   = 2'b10;
          bus.alu_control = ALU_SUB;
          bus.retire      = br_legal;
          bus.pc_write    = br_legal & (bus.funct3[0] ? !bus.zero : bus.zero);
        end
        S_TRAP:  bus.trap = 1'b1;
        default: bus.trap = 1'b0;
      endcase
    end
  end

endmodule
